hci_ecc_manager_target: RTL and testbench

Register-mapped responder on the HCI ECC control bus: it accepts `hci_ecc_req_t` requests and returns `hci_ecc_rsp_t` responses. It counts correctable and uncorrectable ECC events reported by the data and metadata (handshake) decoders of the HCI memory path. It exposes those counters, a control register and a status register to the initiator, and raises a level interrupt on uncorrectable errors. It sits beside the ECC-protected interconnect and is the target end of the bus whose initiator is the system config port.

---
 rtl/hci_package.sv | 45 ++++
 rtl/hci_ecc_sat_counter.sv | 32 +++
 rtl/hci_ecc_manager_target.sv | 131 +++++++++++++
 tb/tb_hci_ecc_manager_target.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hci_package.sv
// Shared HCI ECC control-bus types, register offsets and CTRL layout used by
// the ECC manager target and its initiators.
package hci_package;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [7:0]  wstrb;
        logic        valid;
    } hci_ecc_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } hci_ecc_rsp_t;

    // Packed MSB-first, so count_en lands on bit 0 and irq_en on bit 1.
    typedef struct packed {
        logic irq_en;
        logic count_en;
    } hci_ecc_ctrl_reg_t;

    typedef enum logic {
        HCI_ECC_IDLE = 1'b0,
        HCI_ECC_RESP = 1'b1
    } hci_ecc_state_e;

    localparam logic [7:0] HCI_ECC_REG_DATA_CORR   = 8'h00;
    localparam logic [7:0] HCI_ECC_REG_DATA_UNCORR = 8'h04;
    localparam logic [7:0] HCI_ECC_REG_META_CORR   = 8'h08;
    localparam logic [7:0] HCI_ECC_REG_META_UNCORR = 8'h0C;
    localparam logic [7:0] HCI_ECC_REG_CTRL        = 8'h10;
    localparam logic [7:0] HCI_ECC_REG_STATUS      = 8'h14;
    localparam logic [7:0] HCI_ECC_REG_END         = 8'h18;

    localparam hci_ecc_ctrl_reg_t HCI_ECC_CTRL_RESET = '{irq_en: 1'b0, count_en: 1'b1};

    // Counter idx lives at word offset idx (0: data corr ... 3: meta uncorr).
    function automatic logic [7:0] hci_ecc_cnt_offset(input int unsigned idx);
        return 8'(idx * 4);
    endfunction

endpackage

// File: rtl/hci_ecc_sat_counter.sv
// Saturating event counter; a clear coinciding with an enabled event loads 1
// so the event is never lost.
module hci_ecc_sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] q_o,
    output logic             sat_o
);

    logic [CNT_W-1:0] q_reg;
    logic             bump;

    assign bump  = en_i & inc_i;
    assign sat_o = &q_reg;
    assign q_o   = q_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_reg <= '0;
        end else if (clear_i) begin
            q_reg <= bump ? CNT_W'(1) : '0;
        end else if (bump && !sat_o) begin
            q_reg <= q_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hci_ecc_manager_target.sv
// HCI ECC control-bus target: four saturating ECC event counters, CTRL/STATUS
// registers, a two-state request/response FSM and a registered level irq.
module hci_ecc_manager_target
    import hci_package::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  hci_ecc_req_t req_i,
    output hci_ecc_rsp_t rsp_o,
    input  logic         data_corr_i,
    input  logic         data_uncorr_i,
    input  logic         meta_corr_i,
    input  logic         meta_uncorr_i,
    output logic         irq_o
);

    hci_ecc_state_e    state_reg;
    hci_ecc_ctrl_reg_t ctrl_reg;
    logic [31:0]       rdata_reg;
    logic              error_reg;
    logic              ready_reg;
    logic              irq_reg;

    logic [CNT_W-1:0]  cnt_q [4];
    logic [3:0]        events;
    logic [3:0]        sat;
    logic [3:0]        wr_clr;

    logic [7:0]        offset;
    logic              accept;
    logic              addr_err;
    logic              wr_ok;
    logic              data_uncorr_nz;
    logic              meta_uncorr_nz;
    logic [31:0]       status_val;
    logic [31:0]       rdata_next;
    logic              unused_req_bits;

    assign offset          = req_i.addr[7:0];
    assign unused_req_bits = ^{req_i.addr[31:8], req_i.wdata[31:2], req_i.wstrb[7:4]};

    assign accept   = (state_reg == HCI_ECC_IDLE) && req_i.valid && !clear_i;
    assign addr_err = (offset[1:0] != 2'b00) || (offset >= HCI_ECC_REG_END) ||
                      (req_i.write && (offset == HCI_ECC_REG_STATUS));
    // A write with no low strobes is a legal no-op rather than an error.
    assign wr_ok    = accept && req_i.write && !addr_err;

    assign events = {meta_uncorr_i, meta_corr_i, data_uncorr_i, data_corr_i};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
            assign wr_clr[gi] = wr_ok && (|req_i.wstrb[3:0]) &&
                                (offset == hci_ecc_cnt_offset(gi));

            hci_ecc_sat_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk_i   (clk_i),
                .rst_ni  (rst_ni),
                .clear_i (clear_i | wr_clr[gi]),
                .en_i    (ctrl_reg.count_en),
                .inc_i   (events[gi]),
                .q_o     (cnt_q[gi]),
                .sat_o   (sat[gi])
            );
        end
    endgenerate

    assign data_uncorr_nz = |cnt_q[1];
    assign meta_uncorr_nz = |cnt_q[3];
    assign status_val     = {29'd0, |sat, meta_uncorr_nz, data_uncorr_nz};

    always_comb begin
        rdata_next = '0;
        case (offset)
            HCI_ECC_REG_DATA_CORR:   rdata_next = 32'(cnt_q[0]);
            HCI_ECC_REG_DATA_UNCORR: rdata_next = 32'(cnt_q[1]);
            HCI_ECC_REG_META_CORR:   rdata_next = 32'(cnt_q[2]);
            HCI_ECC_REG_META_UNCORR: rdata_next = 32'(cnt_q[3]);
            HCI_ECC_REG_CTRL:        rdata_next = {30'd0, ctrl_reg};
            HCI_ECC_REG_STATUS:      rdata_next = status_val;
            default:                 rdata_next = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= HCI_ECC_IDLE;
            ctrl_reg  <= HCI_ECC_CTRL_RESET;
            rdata_reg <= '0;
            error_reg <= 1'b0;
            ready_reg <= 1'b0;
            irq_reg   <= 1'b0;
        end else begin
            irq_reg <= ctrl_reg.irq_en & (data_uncorr_nz | meta_uncorr_nz);
            if (clear_i) begin
                state_reg <= HCI_ECC_IDLE;
                ready_reg <= 1'b0;
            end else begin
                case (state_reg)
                    HCI_ECC_IDLE: begin
                        if (accept) begin
                            state_reg <= HCI_ECC_RESP;
                            ready_reg <= 1'b1;
                            error_reg <= addr_err;
                            rdata_reg <= (addr_err || req_i.write) ? '0 : rdata_next;
                            if (wr_ok && (offset == HCI_ECC_REG_CTRL) && req_i.wstrb[0]) begin
                                ctrl_reg <= hci_ecc_ctrl_reg_t'(req_i.wdata[1:0]);
                            end
                        end
                    end
                    HCI_ECC_RESP: begin
                        state_reg <= HCI_ECC_IDLE;
                        ready_reg <= 1'b0;
                    end
                    default: begin
                        state_reg <= HCI_ECC_IDLE;
                        ready_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rsp_o = '{rdata: rdata_reg, error: error_reg, ready: ready_reg};
    assign irq_o = irq_reg;

endmodule

// File: tb/tb_hci_ecc_manager_target.sv
// Bench for hci_ecc_manager_target: a 32-bit and a 4-bit instance share all
// stimulus and are checked against a per-cycle behavioural register model.
module tb_hci_ecc_manager_target;
    import hci_package::*;

    localparam longint MAX32 = 64'h0000_0000_FFFF_FFFF;
    localparam longint MAX4  = 64'd15;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clear = 1'b0;
    hci_ecc_req_t req;
    hci_ecc_rsp_t rsp, rsp4;
    logic         dc = 1'b0, du = 1'b0, mc = 1'b0, mu = 1'b0;
    logic         irq, irq4;

    always #5 clk = ~clk;

    hci_ecc_manager_target #(.CNT_W(32)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .req_i(req), .rsp_o(rsp),
        .data_corr_i(dc), .data_uncorr_i(du), .meta_corr_i(mc), .meta_uncorr_i(mu),
        .irq_o(irq)
    );

    hci_ecc_manager_target #(.CNT_W(4)) u_dut4 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .req_i(req), .rsp_o(rsp4),
        .data_corr_i(dc), .data_uncorr_i(du), .meta_corr_i(mc), .meta_uncorr_i(mu),
        .irq_o(irq4)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: register contents as the spec describes them.
    longint      m_cnt [4];
    longint      m_cnt4 [4];
    bit          m_count_en, m_irq_en, m_irq, m_resp, m_err, m_wr;
    logic [31:0] m_rdata, m_rdata4;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] reg_value(input longint c [4], input longint mx, input logic [7:0] off);
        bit any_sat;
        any_sat = (c[0] == mx) || (c[1] == mx) || (c[2] == mx) || (c[3] == mx);
        if (off < 8'h10) return 32'(c[off[3:2]]);
        if (off == 8'h10) return {30'd0, m_irq_en, m_count_en};
        return {29'd0, any_sat, c[3] != 0, c[1] != 0};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_cnt[i]  = 0;
            m_cnt4[i] = 0;
        end
        m_count_en = 1'b1;
        m_irq_en   = 1'b0;
        m_irq      = 1'b0;
        m_resp     = 1'b0;
    endtask

    // Advance one clock with the current inputs, updating the model alongside.
    task automatic cycle();
        bit         acc, err, wr, nirq, wclr;
        logic [7:0] off;
        logic [3:0] ev;
        off  = req.addr[7:0];
        wr   = req.write;
        acc  = !m_resp && req.valid && !clear;
        err  = (off[1:0] != 2'b00) || (off >= 8'h18) || (wr && off == 8'h14);
        if (acc) begin
            m_err    = err;
            m_wr     = wr;
            m_rdata  = (err || wr) ? 32'd0 : reg_value(m_cnt, MAX32, off);
            m_rdata4 = (err || wr) ? 32'd0 : reg_value(m_cnt4, MAX4, off);
        end
        nirq = m_irq_en && (m_cnt[1] != 0 || m_cnt[3] != 0);
        ev   = {mu, mc, du, dc} & {4{m_count_en}};
        for (int i = 0; i < 4; i++) begin
            wclr = acc && wr && !err && off < 8'h10 && off[3:2] == 2'(i) && req.wstrb[3:0] != 4'd0;
            if (clear || wclr) begin
                m_cnt[i]  = ev[i] ? 1 : 0;
                m_cnt4[i] = ev[i] ? 1 : 0;
            end else if (ev[i]) begin
                if (m_cnt[i] < MAX32) m_cnt[i]++;
                if (m_cnt4[i] < MAX4) m_cnt4[i]++;
            end
        end
        if (acc && wr && !err && off == 8'h10 && req.wstrb[0]) begin
            m_count_en = req.wdata[0];
            m_irq_en   = req.wdata[1];
        end
        m_irq  = nirq;
        m_resp = acc;
        @(posedge clk);
        #1;
        check("ready", 32'(rsp.ready), 32'(m_resp));
        check("irq", 32'(irq), 32'(m_irq));
        if (m_resp) begin
            check("error", 32'(rsp.error), 32'(m_err));
            check("error4", 32'(rsp4.error), 32'(m_err));
            if (m_err || !m_wr) begin
                check("rdata", rsp.rdata, m_rdata);
                check("rdata4", rsp4.rdata, m_rdata4);
            end
        end
    endtask

    task automatic pulse(input logic [3:0] ev, input int n);
        {mu, mc, du, dc} = ev;
        repeat (n) cycle();
        {mu, mc, du, dc} = 4'd0;
    endtask

    // One full access: accept cycle (events ev applied there) then RESP cycle.
    task automatic access(input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                          input logic [7:0] wstrb, input logic [3:0] ev,
                          output logic [31:0] rd, output bit er, output logic [31:0] rd4);
        req = '{addr: addr, write: wr, wdata: wdata, wstrb: wstrb, valid: 1'b1};
        {mu, mc, du, dc} = ev;
        cycle();
        rd  = rsp.rdata;
        er  = rsp.error;
        rd4 = rsp4.rdata;
        req.valid = 1'b0;
        {mu, mc, du, dc} = 4'd0;
        cycle();
        $display("txn addr=0x%08h wr=%0d wdata=0x%08h wstrb=0x%02h -> rdata=0x%08h/0x%08h error=%0d",
                 addr, wr, wdata, wstrb, rd, rd4, er);
    endtask

    typedef struct {
        string       name;
        int          pulses;
        logic [31:0] addr;
        bit          wr;
        logic [31:0] wdata;
        logic [7:0]  wstrb;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [31:0] rd, rd4, r, addr;
        bit          er, wr;
        logic [7:0]  off;

        vecs[0] = '{"rst_ctrl",        0, 32'h0000_0010, 1'b0, 32'h0,         8'h00, 32'h1, 1'b0};
        vecs[1] = '{"rst_status",      0, 32'h0000_0014, 1'b0, 32'h0,         8'h00, 32'h0, 1'b0};
        vecs[2] = '{"rst_data_corr",   0, 32'h0000_0000, 1'b0, 32'h0,         8'h00, 32'h0, 1'b0};
        vecs[3] = '{"unmapped_0x18",   2, 32'h0000_0018, 1'b0, 32'h0,         8'h00, 32'h0, 1'b1};
        vecs[4] = '{"misaligned_0x02", 0, 32'h0000_0002, 1'b0, 32'h0,         8'h00, 32'h0, 1'b1};
        vecs[5] = '{"write_status",    0, 32'h0000_0014, 1'b1, 32'hFFFF_FFFF, 8'hFF, 32'h0, 1'b1};
        vecs[6] = '{"status_kept",     0, 32'h0000_0014, 1'b0, 32'h0,         8'h00, 32'h0, 1'b0};
        vecs[7] = '{"wr_no_strobe",    0, 32'h0000_0000, 1'b1, 32'h0,         8'hF0, 32'h0, 1'b0};
        vecs[8] = '{"data_corr_kept",  0, 32'h0000_0000, 1'b0, 32'h0,         8'h00, 32'h2, 1'b0};
        vecs[9] = '{"upper_addr_ign",  0, 32'hABCD_EF10, 1'b0, 32'h0,         8'h00, 32'h1, 1'b0};

        req = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(rsp.ready), 32'd0);
        check("rst_rdata", rsp.rdata, 32'd0);
        check("rst_error", 32'(rsp.error), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        rst_n = 1'b1;

        for (int v = 0; v < 10; v++) begin
            if (vecs[v].pulses > 0) pulse(4'b0001, vecs[v].pulses);
            access(vecs[v].addr, vecs[v].wr, vecs[v].wdata, vecs[v].wstrb, 4'd0, rd, er, rd4);
            check({vecs[v].name, "_err"}, 32'(er), 32'(vecs[v].exp_err));
            if (!vecs[v].wr || vecs[v].exp_err) check(vecs[v].name, rd, vecs[v].exp_rdata);
        end

        // Uncorrectable data pulses with irq enabled.
        access(32'h10, 1'b1, 32'h3, 8'h01, 4'd0, rd, er, rd4);
        du = 1'b1;
        cycle();
        check("irq_at_e1", 32'(irq), 32'd0);
        cycle();
        check("irq_at_e2", 32'(irq), 32'd1);
        cycle();
        du = 1'b0;
        access(32'h04, 1'b0, 32'h0, 8'h00, 4'd0, rd, er, rd4);
        check("data_uncorr_3", rd, 32'd3);
        access(32'h14, 1'b0, 32'h0, 8'h00, 4'd0, rd, er, rd4);
        check("status_du", rd, 32'h1);

        // Write-clear with a concurrent event keeps the event; plain clear drops irq.
        access(32'h04, 1'b1, 32'h0, 8'h01, 4'b0010, rd, er, rd4);
        access(32'h04, 1'b0, 32'h0, 8'h00, 4'd0, rd, er, rd4);
        check("clr_with_event", rd, 32'd1);
        access(32'h04, 1'b1, 32'hFFFF_FFFF, 8'h0F, 4'd0, rd, er, rd4);
        check("irq_after_clr", 32'(irq), 32'd0);

        // Saturation on the 4-bit instance.
        access(32'h08, 1'b1, 32'h0, 8'h01, 4'd0, rd, er, rd4);
        pulse(4'b0100, 20);
        access(32'h08, 1'b0, 32'h0, 8'h00, 4'd0, rd, er, rd4);
        check("meta_corr_20", rd, 32'd20);
        check("meta_corr_sat4", rd4, 32'hF);
        access(32'h14, 1'b0, 32'h0, 8'h00, 4'd0, rd, er, rd4);
        check("status_nosat", rd, 32'h0);
        check("status_sat4", rd4, 32'h4);

        // count_en=0 drops events.
        access(32'h10, 1'b1, 32'h0, 8'h01, 4'd0, rd, er, rd4);
        pulse(4'b1111, 3);
        access(32'h00, 1'b0, 32'h0, 8'h00, 4'd0, rd, er, rd4);
        check("count_dis_dc", rd, 32'd2);
        access(32'h0C, 1'b0, 32'h0, 8'h00, 4'd0, rd, er, rd4);
        check("count_dis_mu", rd, 32'd0);
        access(32'h10, 1'b1, 32'h1, 8'h01, 4'd0, rd, er, rd4);

        // Global clear concurrent with an event.
        clear = 1'b1;
        mu = 1'b1;
        cycle();
        clear = 1'b0;
        mu = 1'b0;
        access(32'h0C, 1'b0, 32'h0, 8'h00, 4'd0, rd, er, rd4);
        check("clear_with_event", rd, 32'd1);
        access(32'h08, 1'b0, 32'h0, 8'h00, 4'd0, rd, er, rd4);
        check("clear_meta_corr", rd, 32'd0);

        // Async reset while in RESP; reissue afterwards.
        access(32'h10, 1'b1, 32'h3, 8'h01, 4'd0, rd, er, rd4);
        req = '{addr: 32'h10, write: 1'b0, wdata: 32'h0, wstrb: 8'h0, valid: 1'b1};
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_ready", 32'(rsp.ready), 32'd0);
        model_reset();
        #2;
        rst_n = 1'b1;
        cycle();
        req.valid = 1'b0;
        access(32'h10, 1'b0, 32'h0, 8'h00, 4'd0, rd, er, rd4);
        check("reissue_ctrl", rd, 32'h1);
        access(32'h0C, 1'b0, 32'h0, 8'h00, 4'd0, rd, er, rd4);
        check("reset_mu", rd, 32'h0);

        // Randomized traffic against the model.
        for (int t = 0; t < 80; t++) begin
            repeat ($urandom_range(0, 2)) begin
                dc = ($urandom_range(0, 3) == 0);
                du = ($urandom_range(0, 5) == 0);
                mc = ($urandom_range(0, 2) == 0);
                mu = ($urandom_range(0, 7) == 0);
                clear = ($urandom_range(0, 15) == 0);
                cycle();
            end
            clear = 1'b0;
            {mu, mc, du, dc} = 4'd0;
            case ($urandom_range(0, 7))
                0, 1, 2, 3, 4, 5: off = 8'(4 * $urandom_range(0, 5));
                6:       off = 8'(8'h18 + 4 * $urandom_range(0, 57));
                default: off = 8'($urandom_range(0, 255));
            endcase
            r    = $urandom();
            addr = {r[31:8], off};
            wr   = ($urandom_range(0, 1) == 1);
            access(addr, wr, $urandom(), 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)),
                   rd, er, rd4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
